// File: rtl/warp_pkg.sv
// Shared warp-tracking definitions: warp count, warp-id width, per-warp state
// encoding and a population-count helper. Also used by warp_scheduler.
// Optional feature macro: WARP_BARRIER_EN adds the BARRIER warp state.
package warp_pkg;

  localparam int NUM_WARPS = 32;
  localparam int WARP_ID_W = 5;
  localparam int ACT_CNT_W = 6;

  typedef enum logic [2:0] {
    WS_IDLE     = 3'd0,
    WS_READY    = 3'd1,
    WS_STALLED  = 3'd2,
    WS_DRAINING = 3'd3
`ifdef WARP_BARRIER_EN
    ,
    WS_BARRIER  = 3'd4
`endif
  } warp_state_e;

  // Number of set bits in a per-warp flag vector.
  function automatic logic [ACT_CNT_W-1:0] count_ones(input logic [NUM_WARPS-1:0] vec);
    logic [ACT_CNT_W-1:0] cnt;
    cnt = {ACT_CNT_W{1'b0}};
    for (int i = 0; i < NUM_WARPS; i++) begin
      cnt = cnt + {{(ACT_CNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/warp_slot.sv
// One warp's lifecycle FSM plus its outstanding long-latency op counter.
// Produces next-cycle status flags and a combinational illegal-event flag;
// the top level registers them.
// Optional feature macro: WARP_BARRIER_EN.
module warp_slot
  import warp_pkg::*;
#(
  parameter int MAX_OUT = 3,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic reset,
`ifdef WARP_BARRIER_EN
  input  logic barrier_i,
  input  logic release_i,
  output logic in_barrier_o,
  output logic blocking_o,
`endif
  input  logic launch_i,
  input  logic issue_i,
  input  logic issue_long_i,
  input  logic complete_i,
  input  logic exit_i,
  output logic ready_d_o,
  output logic stalled_d_o,
  output logic active_d_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

  warp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_s;
  logic             cnt_err_s;
  logic             bar_err_s;

  // State and counter registers; reset discards all outstanding work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WS_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outstanding-op counter: a legal long issue and a completion cancel out;
  // a completion with nothing outstanding holds at zero and is flagged.
  always_comb begin
    inc_s     = issue_i && issue_long_i && (state_q == WS_READY);
    cnt_d     = cnt_q;
    cnt_err_s = 1'b0;
    if (inc_s && complete_i) begin
      cnt_d = cnt_q;
    end else if (complete_i) begin
      if (cnt_q == CNT_ZERO) begin
        cnt_err_s = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (inc_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next-state logic; exit of a running warp takes priority over everything.
  always_comb begin
    state_d = state_q;
    if (exit_i && (state_q != WS_IDLE) && (state_q != WS_DRAINING)) begin
      state_d = (cnt_d == CNT_ZERO) ? WS_IDLE : WS_DRAINING;
    end else begin
      case (state_q)
        WS_IDLE: begin
          if (launch_i && !exit_i) state_d = WS_READY;
          else                     state_d = WS_IDLE;
        end
        WS_READY: begin
`ifdef WARP_BARRIER_EN
          if (barrier_i)                state_d = WS_BARRIER;
          else if (cnt_d == CNT_MAX)    state_d = WS_STALLED;
          else                          state_d = WS_READY;
`else
          if (cnt_d == CNT_MAX) state_d = WS_STALLED;
          else                  state_d = WS_READY;
`endif
        end
        WS_STALLED: begin
          if (cnt_d < CNT_MAX) state_d = WS_READY;
          else                 state_d = WS_STALLED;
        end
        WS_DRAINING: begin
          if (cnt_d == CNT_ZERO) state_d = WS_IDLE;
          else                   state_d = WS_DRAINING;
        end
`ifdef WARP_BARRIER_EN
        WS_BARRIER: begin
          if (release_i) state_d = (cnt_d == CNT_MAX) ? WS_STALLED : WS_READY;
          else           state_d = WS_BARRIER;
        end
`endif
        default: state_d = WS_IDLE;
      endcase
    end
  end

`ifdef WARP_BARRIER_EN
  // Barrier bookkeeping seen by the top-level release logic.
  always_comb begin
    bar_err_s    = barrier_i && (state_q != WS_READY);
    in_barrier_o = (state_q == WS_BARRIER);
    blocking_o   = (state_q == WS_READY) || (state_q == WS_STALLED);
  end
`else
  // No barrier support in this build.
  always_comb begin
    bar_err_s = 1'b0;
  end
`endif

  // Output decode of the next state plus the illegal-event summary.
  always_comb begin
    ready_d_o   = (state_d == WS_READY);
    stalled_d_o = (state_d == WS_STALLED) || (state_d == WS_DRAINING)
`ifdef WARP_BARRIER_EN
                  || (state_d == WS_BARRIER)
`endif
                  ;
    active_d_o  = (state_d != WS_IDLE);
    err_o       = cnt_err_s
                  || (launch_i && !exit_i && (state_q != WS_IDLE))
                  || (issue_i && (state_q != WS_READY))
                  || (exit_i && (state_q == WS_IDLE))
                  || bar_err_s;
  end

endmodule

// File: rtl/warp_status_tracker.sv
// Tracks the lifecycle of NUM_WARPS warps: decodes launch/issue/complete/exit
// events to per-warp slots and registers ready/stalled masks, the active-warp
// count and a one-cycle error pulse.
// Optional feature macro: WARP_BARRIER_EN adds barrier_valid/barrier_warp.
module warp_status_tracker
  import warp_pkg::*;
#(
  parameter int MAX_OUT = 3,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef WARP_BARRIER_EN
  input  logic                 barrier_valid,
  input  logic [WARP_ID_W-1:0] barrier_warp,
`endif
  input  logic                 launch_valid,
  input  logic [WARP_ID_W-1:0] launch_warp,
  input  logic                 issue_valid,
  input  logic [WARP_ID_W-1:0] issue_warp,
  input  logic                 issue_long,
  input  logic                 complete_valid,
  input  logic [WARP_ID_W-1:0] complete_warp,
  input  logic                 exit_valid,
  input  logic [WARP_ID_W-1:0] exit_warp,
  output logic [NUM_WARPS-1:0] warp_ready,
  output logic [NUM_WARPS-1:0] warp_stalled,
  output logic [ACT_CNT_W-1:0] active_count,
  output logic                 err
);

  logic [NUM_WARPS-1:0] launch_hit_s, issue_hit_s, complete_hit_s, exit_hit_s;
  logic [NUM_WARPS-1:0] ready_d_s, stalled_d_s, active_d_s, slot_err_s;
  logic [NUM_WARPS-1:0] warp_ready_q, warp_stalled_q;
  logic [ACT_CNT_W-1:0] active_count_q;
  logic                 err_q;

  // One-hot decode of each event port onto the warp slots.
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      launch_hit_s[i]   = launch_valid   && (launch_warp   == WARP_ID_W'(i));
      issue_hit_s[i]    = issue_valid    && (issue_warp    == WARP_ID_W'(i));
      complete_hit_s[i] = complete_valid && (complete_warp == WARP_ID_W'(i));
      exit_hit_s[i]     = exit_valid     && (exit_warp     == WARP_ID_W'(i));
    end
  end

`ifdef WARP_BARRIER_EN
  logic [NUM_WARPS-1:0] barrier_hit_s, in_barrier_s, blocking_s;
  logic                 release_s;

  // Barrier decode and release: release once no running warp is still outside it.
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      barrier_hit_s[i] = barrier_valid && (barrier_warp == WARP_ID_W'(i));
    end
    release_s = (|in_barrier_s) && !(|blocking_s);
  end
`endif

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
    warp_slot #(
      .MAX_OUT (MAX_OUT),
      .CNT_W   (CNT_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
`ifdef WARP_BARRIER_EN
      .barrier_i    (barrier_hit_s[g]),
      .release_i    (release_s),
      .in_barrier_o (in_barrier_s[g]),
      .blocking_o   (blocking_s[g]),
`endif
      .launch_i     (launch_hit_s[g]),
      .issue_i      (issue_hit_s[g]),
      .issue_long_i (issue_long),
      .complete_i   (complete_hit_s[g]),
      .exit_i       (exit_hit_s[g]),
      .ready_d_o    (ready_d_s[g]),
      .stalled_d_o  (stalled_d_s[g]),
      .active_d_o   (active_d_s[g]),
      .err_o        (slot_err_s[g])
    );
  end

  // Output registers, aligned with the slot state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warp_ready_q   <= {NUM_WARPS{1'b0}};
      warp_stalled_q <= {NUM_WARPS{1'b0}};
      active_count_q <= {ACT_CNT_W{1'b0}};
      err_q          <= 1'b0;
    end else begin
      warp_ready_q   <= ready_d_s;
      warp_stalled_q <= stalled_d_s;
      active_count_q <= count_ones(active_d_s);
      err_q          <= |slot_err_s;
    end
  end

  assign warp_ready   = warp_ready_q;
  assign warp_stalled = warp_stalled_q;
  assign active_count = active_count_q;
  assign err          = err_q;

endmodule

// File: tb/tb_warp_status_tracker.sv
// Directed scoreboard bench for warp_status_tracker (default build, MAX_OUT = 3).
module tb_warp_status_tracker;

  logic        clk;
  logic        reset;
  logic        launch_valid, issue_valid, issue_long, complete_valid, exit_valid;
  logic [4:0]  launch_warp, issue_warp, complete_warp, exit_warp;
  logic [31:0] warp_ready, warp_stalled;
  logic [5:0]  active_count;
  logic        err;

  typedef struct packed {
    logic [31:0] rdy;
    logic [31:0] stl;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  warp_status_tracker #(.MAX_OUT(3), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .launch_valid   (launch_valid),
    .launch_warp    (launch_warp),
    .issue_valid    (issue_valid),
    .issue_warp     (issue_warp),
    .issue_long     (issue_long),
    .complete_valid (complete_valid),
    .complete_warp  (complete_warp),
    .exit_valid     (exit_valid),
    .exit_warp      (exit_warp),
    .warp_ready     (warp_ready),
    .warp_stalled   (warp_stalled),
    .active_count   (active_count),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    launch_valid = 1'b0; launch_warp = 5'd0;
    issue_valid = 1'b0; issue_warp = 5'd0; issue_long = 1'b0;
    complete_valid = 1'b0; complete_warp = 5'd0;
    exit_valid = 1'b0; exit_warp = 5'd0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] r, input logic [31:0] s,
                            input logic [5:0] a, input logic e);
    exp_t x;
    x.rdy = r; x.stl = s; x.cnt = a; x.err = e;
    sb_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic compare_head();
    exp_t  x;
    string t;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end else begin
      x = sb_q.pop_front();
      t = tag_q.pop_front();
      tests++;
      assert (warp_ready === x.rdy) else begin
        fails++;
        $error("FAIL %s warp_ready observed=%h expected=%h", t, warp_ready, x.rdy);
      end
      tests++;
      assert (warp_stalled === x.stl) else begin
        fails++;
        $error("FAIL %s warp_stalled observed=%h expected=%h", t, warp_stalled, x.stl);
      end
      tests++;
      assert (active_count === x.cnt) else begin
        fails++;
        $error("FAIL %s active_count observed=%0d expected=%0d", t, active_count, x.cnt);
      end
      tests++;
      assert (err === x.err) else begin
        fails++;
        $error("FAIL %s err observed=%b expected=%b", t, err, x.err);
      end
    end
  endtask

  // Let the sampling edge pass, check #1 after it, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    compare_head();
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    logic [31:0] st;
    reset = 1'b0;
    clear_inputs();
    #2;
    expect_out("reset_state", 32'h0, 32'h0, 6'd0, 1'b0);
    compare_head();
    @(negedge clk);
    reset = 1'b1;

    // Launch warps 0, 1, 2.
    launch_valid = 1'b1; launch_warp = 5'd0;
    expect_out("launch_w0", 32'h1, 32'h0, 6'd1, 1'b0); tick();
    launch_valid = 1'b1; launch_warp = 5'd1;
    expect_out("launch_w1", 32'h3, 32'h0, 6'd2, 1'b0); tick();
    launch_valid = 1'b1; launch_warp = 5'd2;
    expect_out("launch_w2", 32'h7, 32'h0, 6'd3, 1'b0); tick();

    // Three long issues to warp 0 reach MAX_OUT and stall it.
    issue_valid = 1'b1; issue_warp = 5'd0; issue_long = 1'b1;
    expect_out("w0_long1", 32'h7, 32'h0, 6'd3, 1'b0); tick();
    issue_valid = 1'b1; issue_warp = 5'd0; issue_long = 1'b1;
    expect_out("w0_long2", 32'h7, 32'h0, 6'd3, 1'b0); tick();
    issue_valid = 1'b1; issue_warp = 5'd0; issue_long = 1'b1;
    expect_out("w0_stall", 32'h6, 32'h1, 6'd3, 1'b0); tick();
    complete_valid = 1'b1; complete_warp = 5'd0;
    expect_out("w0_unstall", 32'h7, 32'h0, 6'd3, 1'b0); tick();

    // Independent events on different warps in one cycle.
    issue_valid = 1'b1; issue_warp = 5'd2; issue_long = 1'b1;
    complete_valid = 1'b1; complete_warp = 5'd0;
    expect_out("w2_long_w0_cpl", 32'h7, 32'h0, 6'd3, 1'b0); tick();
    issue_valid = 1'b1; issue_warp = 5'd2; issue_long = 1'b1;
    launch_valid = 1'b1; launch_warp = 5'd3;
    expect_out("w2_long_w3_launch", 32'hF, 32'h0, 6'd4, 1'b0); tick();

    // Warp 2 at 2 outstanding: issue+complete cancel, next issue stalls.
    issue_valid = 1'b1; issue_warp = 5'd2; issue_long = 1'b1;
    complete_valid = 1'b1; complete_warp = 5'd2;
    expect_out("w2_issue_cpl_same", 32'hF, 32'h0, 6'd4, 1'b0); tick();
    issue_valid = 1'b1; issue_warp = 5'd2; issue_long = 1'b1;
    expect_out("w2_stall", 32'hB, 32'h4, 6'd4, 1'b0); tick();
    exit_valid = 1'b1; exit_warp = 5'd2;
    expect_out("w2_draining", 32'hB, 32'h4, 6'd4, 1'b0); tick();
    complete_valid = 1'b1; complete_warp = 5'd2;
    expect_out("w2_drain_cpl1", 32'hB, 32'h4, 6'd4, 1'b0); tick();
    complete_valid = 1'b1; complete_warp = 5'd2;
    expect_out("w2_drain_cpl2", 32'hB, 32'h4, 6'd4, 1'b0); tick();
    complete_valid = 1'b1; complete_warp = 5'd2;
    expect_out("w2_idle", 32'hB, 32'h0, 6'd3, 1'b0); tick();

    // Illegal events: one-cycle err pulse, no state change.
    complete_valid = 1'b1; complete_warp = 5'd5;
    expect_out("err_cpl_w5_zero", 32'hB, 32'h0, 6'd3, 1'b1); tick();
    expect_out("err_pulse_end1", 32'hB, 32'h0, 6'd3, 1'b0); tick();
    launch_valid = 1'b1; launch_warp = 5'd1;
    expect_out("err_launch_ready_w1", 32'hB, 32'h0, 6'd3, 1'b1); tick();
    issue_valid = 1'b1; issue_warp = 5'd9; issue_long = 1'b1;
    expect_out("err_issue_idle_w9", 32'hB, 32'h0, 6'd3, 1'b1); tick();
    expect_out("err_pulse_end2", 32'hB, 32'h0, 6'd3, 1'b0); tick();
    exit_valid = 1'b1; exit_warp = 5'd9;
    expect_out("err_exit_idle_w9", 32'hB, 32'h0, 6'd3, 1'b1); tick();

    // Same-warp launch and exit: exit wins, no err.
    launch_valid = 1'b1; launch_warp = 5'd3;
    exit_valid = 1'b1; exit_warp = 5'd3;
    expect_out("w3_launch_exit", 32'h3, 32'h0, 6'd2, 1'b0); tick();
    exit_valid = 1'b1; exit_warp = 5'd1;
    expect_out("w1_exit", 32'h1, 32'h0, 6'd1, 1'b0); tick();

    // Warp 0 back to zero outstanding, then an underflowing completion.
    complete_valid = 1'b1; complete_warp = 5'd0;
    expect_out("w0_cpl_to_zero", 32'h1, 32'h0, 6'd1, 1'b0); tick();
    complete_valid = 1'b1; complete_warp = 5'd0;
    expect_out("err_w0_underflow", 32'h1, 32'h0, 6'd1, 1'b1); tick();
    exit_valid = 1'b1; exit_warp = 5'd0;
    expect_out("w0_exit_no_wrap", 32'h0, 32'h0, 6'd0, 1'b0); tick();

    // Warps 0..3 launched and driven to stalled.
    for (int w = 0; w < 4; w++) begin
      launch_valid = 1'b1; launch_warp = 5'(w);
      expect_out($sformatf("launch_loop_w%0d", w), (32'h1 << (w + 1)) - 32'h1, 32'h0,
                 6'(w + 1), 1'b0);
      tick();
    end
    st = 32'h0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
        issue_valid = 1'b1; issue_warp = 5'(w); issue_long = 1'b1;
        if (k == 2) st = st | (32'h1 << w);
        expect_out($sformatf("stall_w%0d_k%0d", w, k), 32'hF & ~st, st, 6'd4, 1'b0);
        tick();
      end
    end

    // Asynchronous reset mid-operation clears outputs at once.
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 32'h0, 32'h0, 6'd0, 1'b0);
    compare_head();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    expect_out("post_reset_idle", 32'h0, 32'h0, 6'd0, 1'b0); tick();
    complete_valid = 1'b1; complete_warp = 5'd0;
    expect_out("late_cpl_err", 32'h0, 32'h0, 6'd0, 1'b1); tick();
    expect_out("late_cpl_end", 32'h0, 32'h0, 6'd0, 1'b0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
